// File: rtl/vx_writeback_merge_if.sv
// ----------------------------------------------------------------------------
// vx_writeback_merge_if
// Bundles the NUM_CH writeback input channels and the merged output port of
// vx_writeback_merge.
//   in_valid/in_data/in_sop/in_eop : per-channel beat offered by an execute unit
//   in_ready                       : per-channel buffer has room for a beat
//   out_valid/out_data/out_sop/out_eop/out_ch : merged beat toward the regfile
//   out_ready                      : sink accepts the merged beat
//   proto_err                      : sticky per-channel framing error flags
// Modports: slave = the merge block, master = producers/sink around it.
// ----------------------------------------------------------------------------
interface vx_writeback_merge_if #(
   parameter int NUM_CH = 4,
   parameter int DATAW  = 128
);
   localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [NUM_CH-1:0]       in_valid;
   logic [NUM_CH*DATAW-1:0] in_data;
   logic [NUM_CH-1:0]       in_sop;
   logic [NUM_CH-1:0]       in_eop;
   logic [NUM_CH-1:0]       in_ready;
   logic                    out_valid;
   logic [DATAW-1:0]        out_data;
   logic                    out_sop;
   logic                    out_eop;
   logic [CHW-1:0]          out_ch;
   logic                    out_ready;
   logic [NUM_CH-1:0]       proto_err;

   modport slave (
      input  in_valid, in_data, in_sop, in_eop, out_ready,
      output in_ready, out_valid, out_data, out_sop, out_eop, out_ch, proto_err
   );

   modport master (
      output in_valid, in_data, in_sop, in_eop, out_ready,
      input  in_ready, out_valid, out_data, out_sop, out_eop, out_ch, proto_err
   );
endinterface

// File: rtl/vx_writeback_merge.sv
// ----------------------------------------------------------------------------
// vx_writeback_merge
// Merges NUM_CH writeback channels into one register-file write port. Each
// channel owns a DEPTH-entry FIFO; a round-robin arbiter grants a channel and
// then stays locked on it until the packet's eop beat leaves, so multi-beat
// packets never interleave. Each channel input is framing-checked (sop/eop
// ordering) and flags a sticky proto_err; offending beats still pass through.
// Ports:
//   clk     : clock
//   reset_n : asynchronous active-low reset (flushes FIFOs, arbiter, errors)
//   bus     : vx_writeback_merge_if.slave (all channel and output signals)
// ----------------------------------------------------------------------------
module vx_writeback_merge #(
   parameter int NUM_CH = 4,
   parameter int DEPTH  = 4,
   parameter int DATAW  = 128
) (
   input  logic                  clk,
   input  logic                  reset_n,
   vx_writeback_merge_if.slave   bus
);
   localparam int CHW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int PW   = $clog2(DEPTH);
   localparam int CNTW = PW + 1;
   localparam int EW   = DATAW + 2;   // stored entry: {data, sop, eop}

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_LOCK = 1'b1;

   // Next channel index, wrapping at NUM_CH (NUM_CH need not be a power of 2).
   function automatic logic [CHW-1:0] f_next_ch(input logic [CHW-1:0] c);
      logic [CHW-1:0] n;
      if (c == CHW'(NUM_CH - 1)) begin
         n = '0;
      end else begin
         n = c + CHW'(1);
      end
      return n;
   endfunction

   logic [EW-1:0]   r_mem    [NUM_CH][DEPTH];
   logic [PW-1:0]   r_wr_ptr [NUM_CH];
   logic [PW-1:0]   r_rd_ptr [NUM_CH];
   logic [CNTW-1:0] r_cnt    [NUM_CH];
   logic [NUM_CH-1:0] r_in_pkt;
   logic [NUM_CH-1:0] r_proto_err;

   logic [0:0]      r_state;
   logic [CHW-1:0]  r_lock_ch;
   logic [CHW-1:0]  r_rr_ptr;

   logic [NUM_CH-1:0] w_full;
   logic [NUM_CH-1:0] w_empty;
   logic [NUM_CH-1:0] w_push;
   logic [NUM_CH-1:0] w_pop;
   logic [EW-1:0]     w_head [NUM_CH];
   logic [CHW-1:0]    w_gnt;
   logic [CHW-1:0]    w_idx;
   logic              w_any;
   logic              w_out_pop;
   logic [EW-1:0]     w_sel;

   // ------------------------------------------------------------------------
   // Per-channel FIFO and framing checker
   // ------------------------------------------------------------------------
   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign w_full[g]  = (r_cnt[g] == CNTW'(DEPTH));
      assign w_empty[g] = (r_cnt[g] == CNTW'(0));
      // A full buffer refuses a push even when it is popped the same cycle.
      assign w_push[g]  = bus.in_valid[g] & ~w_full[g];
      assign w_pop[g]   = w_out_pop & (w_gnt == CHW'(g));
      assign w_head[g]  = r_mem[g][r_rd_ptr[g]];

      // Storage array; contents are don't-care while the entry is unoccupied.
      always_ff @(posedge clk) begin
         if (w_push[g]) begin
            r_mem[g][r_wr_ptr[g]] <= {bus.in_data[g*DATAW +: DATAW],
                                      bus.in_sop[g], bus.in_eop[g]};
         end
      end

      // FIFO pointers and occupancy.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            r_wr_ptr[g] <= '0;
            r_rd_ptr[g] <= '0;
            r_cnt[g]    <= '0;
         end else begin
            if (w_push[g]) begin
               r_wr_ptr[g] <= r_wr_ptr[g] + PW'(1);
            end
            if (w_pop[g]) begin
               r_rd_ptr[g] <= r_rd_ptr[g] + PW'(1);
            end
            case ({w_push[g], w_pop[g]})
               2'b10:   r_cnt[g] <= r_cnt[g] + CNTW'(1);
               2'b01:   r_cnt[g] <= r_cnt[g] - CNTW'(1);
               default: r_cnt[g] <= r_cnt[g];
            endcase
         end
      end

      // Framing tracker: sop must open a packet, non-sop must continue one.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            r_in_pkt[g]    <= 1'b0;
            r_proto_err[g] <= 1'b0;
         end else if (w_push[g]) begin
            if (bus.in_sop[g] == r_in_pkt[g]) begin
               r_proto_err[g] <= 1'b1;
            end
            if (bus.in_eop[g]) begin
               r_in_pkt[g] <= 1'b0;
            end else if (bus.in_sop[g]) begin
               r_in_pkt[g] <= 1'b1;
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Arbitration
   // ------------------------------------------------------------------------
   // Grant select: locked channel only, else first non-empty from rr_ptr.
   always_comb begin
      w_gnt = r_lock_ch;
      w_any = 1'b0;
      w_idx = r_rr_ptr;
      if (r_state == ST_LOCK) begin
         w_gnt = r_lock_ch;
         w_any = ~w_empty[r_lock_ch];
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (!w_any && !w_empty[w_idx]) begin
               w_gnt = w_idx;
               w_any = 1'b1;
            end else begin
               w_gnt = w_gnt;
               w_any = w_any;
            end
            w_idx = f_next_ch(w_idx);
         end
      end
   end

   assign w_sel     = w_head[w_gnt];
   assign w_out_pop = w_any & bus.out_ready;

   // Arbiter state: a presented-but-stalled or non-eop beat locks the channel,
   // so the presented beat cannot change under backpressure.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= ST_IDLE;
         r_lock_ch <= '0;
         r_rr_ptr  <= '0;
      end else if (w_out_pop) begin
         if (w_sel[0]) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= f_next_ch(w_gnt);
         end else begin
            r_state   <= ST_LOCK;
            r_lock_ch <= w_gnt;
         end
      end else if ((r_state == ST_IDLE) && w_any) begin
         r_state   <= ST_LOCK;
         r_lock_ch <= w_gnt;
      end
   end

   assign bus.in_ready  = ~w_full;
   assign bus.out_valid = w_any;
   assign bus.out_data  = w_sel[EW-1:2];
   assign bus.out_sop   = w_sel[1];
   assign bus.out_eop   = w_sel[0];
   assign bus.out_ch    = w_gnt;
   assign bus.proto_err = r_proto_err;

endmodule

// File: tb/tb_vx_writeback_merge.sv
// ----------------------------------------------------------------------------
// tb_vx_writeback_merge
// Directed stimulus for vx_writeback_merge. Expected merged beats are queued
// in arbitration order when stimulus is issued; an independent monitor pops
// and compares each beat the DUT hands over (out_valid && out_ready).
// ----------------------------------------------------------------------------
module tb_vx_writeback_merge;
   localparam int NUM_CH = 4;
   localparam int DEPTH  = 4;
   localparam int DATAW  = 128;
   localparam int IW     = 2 + 2 + DATAW;   // {ch, sop, eop, data}

   logic clk;
   logic reset_n;
   int   n_checks;
   int   n_errors;
   logic [IW-1:0] sb [$];
   logic [IW-1:0] mon_act;
   logic [IW-1:0] mon_exp;
   logic [DATAW+4:0] snap;

   vx_writeback_merge_if #(.NUM_CH(NUM_CH), .DATAW(DATAW)) bus ();

   vx_writeback_merge #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .DATAW(DATAW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [IW-1:0] mk(input int ch, input logic [31:0] d,
                                       input logic s, input logic e);
      return {2'(ch), s, e, DATAW'(d)};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ch(input int ch, input logic [31:0] d, input logic s, input logic e);
      bus.in_valid[ch] = 1'b1;
      bus.in_data[ch*DATAW +: DATAW] = DATAW'(d);
      bus.in_sop[ch] = s;
      bus.in_eop[ch] = e;
   endtask

   task automatic push1(input int ch, input logic [31:0] d, input logic s, input logic e);
      set_ch(ch, d, s, e);
      cyc();
      bus.in_valid[ch] = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 100; i++) begin
         if (sb.size() == 0) break;
         cyc();
      end
      chk("drain_empty", 32'(sb.size()), 32'd0);
      cyc();
   endtask

   // Scoreboard monitor: compare every accepted merged beat with the queue head.
   always @(negedge clk) begin
      if (reset_n && bus.out_valid && bus.out_ready) begin
         mon_act = {bus.out_ch, bus.out_sop, bus.out_eop, bus.out_data};
         n_checks++;
         if (sb.size() == 0) begin
            n_errors++;
            $display("FAIL mon_unexpected: got %0h, required no beat", mon_act);
         end else begin
            mon_exp = sb.pop_front();
            if (mon_act !== mon_exp) begin
               n_errors++;
               $display("FAIL mon_beat: got %0h, required %0h", mon_act, mon_exp);
            end
         end
      end
   end

   // Global time limit.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, required finish");
      $fatal(1, "timeout");
   end

   initial begin
      n_checks      = 0;
      n_errors      = 0;
      reset_n       = 1'b0;
      bus.in_valid  = '0;
      bus.in_data   = '0;
      bus.in_sop    = '0;
      bus.in_eop    = '0;
      bus.out_ready = 1'b0;
      #12;
      chk("rst_in_ready",  32'(bus.in_ready),  32'hF);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_proto_err", 32'(bus.proto_err), 32'd0);
      cyc();
      cyc();
      reset_n = 1'b1;
      cyc();

      // 1: single beat on ch2, visible the cycle after the push.
      bus.out_ready = 1'b1;
      set_ch(2, 32'hA5, 1'b1, 1'b1);
      sb.push_back(mk(2, 32'hA5, 1'b1, 1'b1));
      chk("t1_no_bypass", 32'(bus.out_valid), 32'd0);
      cyc();
      bus.in_valid[2] = 1'b0;
      chk("t1_valid", 32'(bus.out_valid), 32'd1);
      chk("t1_ch",    32'(bus.out_ch),    32'd2);
      // ch3 beat moves rr_ptr back to 0.
      sb.push_back(mk(3, 32'h33, 1'b1, 1'b1));
      push1(3, 32'h33, 1'b1, 1'b1);
      drain();

      // 2: all channels hold two single-beat packets; round-robin, no bubbles.
      bus.out_ready = 1'b0;
      for (int b = 0; b < 2; b++) begin
         for (int c = 0; c < NUM_CH; c++) begin
            set_ch(c, 32'(16 * c + b), 1'b1, 1'b1);
            sb.push_back(mk(c, 32'(16 * c + b), 1'b1, 1'b1));
         end
         cyc();
      end
      bus.in_valid = '0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("t2_no_bubble", 32'(bus.out_valid), 32'd1);
      end
      drain();

      // 3: ch0 3-beat packet with gaps locks out a pending ch1 beat.
      set_ch(0, 32'h100, 1'b1, 1'b0);
      set_ch(1, 32'h200, 1'b1, 1'b1);
      sb.push_back(mk(0, 32'h100, 1'b1, 1'b0));
      cyc();
      bus.in_valid = '0;
      cyc();
      chk("t3_gap_a", 32'(bus.out_valid), 32'd0);
      cyc();
      chk("t3_gap_b", 32'(bus.out_valid), 32'd0);
      sb.push_back(mk(0, 32'h101, 1'b0, 1'b0));
      push1(0, 32'h101, 1'b0, 1'b0);
      cyc();
      chk("t3_gap_c", 32'(bus.out_valid), 32'd0);
      cyc();
      chk("t3_gap_d", 32'(bus.out_valid), 32'd0);
      sb.push_back(mk(0, 32'h102, 1'b0, 1'b1));
      sb.push_back(mk(1, 32'h200, 1'b1, 1'b1));
      push1(0, 32'h102, 1'b0, 1'b1);
      chk("t3_eop_ch", 32'(bus.out_ch),  32'd0);
      chk("t3_eop",    32'(bus.out_eop), 32'd1);
      cyc();
      chk("t3_ch1_valid", 32'(bus.out_valid), 32'd1);
      chk("t3_ch1_ch",    32'(bus.out_ch),    32'd1);
      drain();

      // 4: backpressure holds outputs; ch1 fills and refuses further beats.
      bus.out_ready = 1'b0;
      sb.push_back(mk(1, 32'h300, 1'b1, 1'b0));
      push1(1, 32'h300, 1'b1, 1'b0);
      chk("t4_valid", 32'(bus.out_valid), 32'd1);
      snap = {bus.out_valid, bus.out_ch, bus.out_sop, bus.out_eop, bus.out_data};
      sb.push_back(mk(1, 32'h301, 1'b0, 1'b0));
      push1(1, 32'h301, 1'b0, 1'b0);
      chk("t4_stable", 32'({bus.out_valid, bus.out_ch, bus.out_sop, bus.out_eop, bus.out_data} == snap), 32'd1);
      sb.push_back(mk(1, 32'h302, 1'b0, 1'b0));
      push1(1, 32'h302, 1'b0, 1'b0);
      chk("t4_stable", 32'({bus.out_valid, bus.out_ch, bus.out_sop, bus.out_eop, bus.out_data} == snap), 32'd1);
      chk("t4_ready_3", 32'(bus.in_ready[1]), 32'd1);
      sb.push_back(mk(1, 32'h303, 1'b0, 1'b1));
      push1(1, 32'h303, 1'b0, 1'b1);
      chk("t4_stable", 32'({bus.out_valid, bus.out_ch, bus.out_sop, bus.out_eop, bus.out_data} == snap), 32'd1);
      chk("t4_full", 32'(bus.in_ready[1]), 32'd0);
      set_ch(1, 32'h3FF, 1'b1, 1'b1);   // must be refused while full
      cyc();
      chk("t4_stable", 32'({bus.out_valid, bus.out_ch, bus.out_sop, bus.out_eop, bus.out_data} == snap), 32'd1);
      cyc();
      chk("t4_stable", 32'({bus.out_valid, bus.out_ch, bus.out_sop, bus.out_eop, bus.out_data} == snap), 32'd1);
      bus.out_ready = 1'b1;             // pop and refused push in the same cycle
      cyc();
      bus.in_valid[1] = 1'b0;
      chk("t4_ready_after_pop", 32'(bus.in_ready[1]), 32'd1);
      drain();

      // 5: double sop on ch3 flags a sticky error; beats pass through in order.
      sb.push_back(mk(3, 32'h400, 1'b1, 1'b0));
      push1(3, 32'h400, 1'b1, 1'b0);
      chk("t5_no_err", 32'(bus.proto_err), 32'd0);
      sb.push_back(mk(3, 32'h401, 1'b1, 1'b0));
      push1(3, 32'h401, 1'b1, 1'b0);
      chk("t5_err", 32'(bus.proto_err), 32'h8);
      sb.push_back(mk(3, 32'h402, 1'b0, 1'b1));
      push1(3, 32'h402, 1'b0, 1'b1);
      cyc();
      cyc();
      chk("t5_err_held", 32'(bus.proto_err), 32'h8);
      drain();
      chk("t5_err_held2", 32'(bus.proto_err), 32'h8);

      // 6: reset while locked on ch1 mid-packet, then ch0 wins after release.
      sb.push_back(mk(1, 32'h500, 1'b1, 1'b0));
      push1(1, 32'h500, 1'b1, 1'b0);
      cyc();
      bus.out_ready = 1'b0;
      push1(1, 32'h501, 1'b0, 1'b0);    // stalled, flushed by reset
      cyc();
      #1;
      reset_n = 1'b0;
      #1;
      chk("t6_rst_valid",    32'(bus.out_valid), 32'd0);
      chk("t6_rst_ready",    32'(bus.in_ready),  32'hF);
      chk("t6_rst_proto",    32'(bus.proto_err), 32'd0);
      sb.delete();
      cyc();
      reset_n = 1'b1;
      cyc();
      bus.out_ready = 1'b1;
      set_ch(1, 32'h601, 1'b1, 1'b1);
      set_ch(0, 32'h600, 1'b1, 1'b1);
      sb.push_back(mk(0, 32'h600, 1'b1, 1'b1));
      sb.push_back(mk(1, 32'h601, 1'b1, 1'b1));
      cyc();
      bus.in_valid = '0;
      chk("t6_first_grant", 32'(bus.out_ch), 32'd0);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
